// File: rtl/uart_apb_pkg.sv
// Shared types for the UART APB initiator and glue slave.
package uart_apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/uart_apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer, one response out.
// Optional ACCESS wait timeout via UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PERROR
);

  apb_mst_state_e    r_state;
  apb_mst_state_e    w_state;
  logic              r_psel;
  logic              w_psel;
  logic              r_penable;
  logic              w_penable;
  logic              r_pwrite;
  logic              w_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [ADDR_W-1:0] w_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] w_pwdata;
  logic              r_rsp_valid;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              r_rsp_err;
  logic              w_rsp_err;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait;
`endif

  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
`ifdef UART_APB_MASTER_TIMEOUT_EN
    w_wait      = r_wait;
`endif
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_pwrite = cmd_write;
          w_paddr  = cmd_addr;
          w_pwdata = cmd_wdata;
          w_psel   = 1'b1;
          w_state  = SETUP;
        end
      end
      SETUP: begin
        w_penable = 1'b1;
        w_state   = ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
        w_wait    = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          w_rsp_rdata = r_pwrite ? '0 : PRDATA;
          w_rsp_err   = PERROR;
          w_rsp_valid = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_state     = RESP;
        end
`ifdef UART_APB_MASTER_TIMEOUT_EN
        // Last permitted wait cycle with PREADY still low
        else if (r_wait == WAIT_LAST) begin
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b1;
          w_rsp_valid = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_state     = RESP;
        end else begin
          w_wait = r_wait + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
    end
  end

`ifdef UART_APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait;
    end
  end
`endif

  assign cmd_ready = (r_state == IDLE);
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master; slave side driven by hand.
module tb_uart_apb_master;

  logic       PCLK;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PERROR;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  uart_apb_master #(
    .ADDR_W(8),
    .DATA_W(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PERROR   (PERROR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    PRDATA    = 8'h00;
    PREADY    = 1'b1;
    PERROR    = 1'b0;

    // Reset state
    step();
    step();
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_pen", PENABLE, 1'b0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk8("rst_paddr", PADDR, 8'h00);
    chk8("rst_pwdata", PWDATA, 8'h00);
    chk1("rst_rspv", rsp_valid, 1'b0);
    chk8("rst_rdata", rsp_rdata, 8'h00);
    chk1("rst_err", rsp_err, 1'b0);
    PRESET = 1'b0;
    step();
    chk1("idle_rdy", cmd_ready, 1'b1);

    // Zero-wait write
    issue(1'b1, 8'h04, 8'hA5);
    step();
    cmd_valid = 1'b0;
    chk1("w_setup_psel", PSEL, 1'b1);
    chk1("w_setup_pen", PENABLE, 1'b0);
    chk1("w_pwrite", PWRITE, 1'b1);
    chk8("w_paddr", PADDR, 8'h04);
    chk8("w_pwdata", PWDATA, 8'hA5);
    chk1("w_setup_rdy", cmd_ready, 1'b0);
    step();
    chk1("w_acc_psel", PSEL, 1'b1);
    chk1("w_acc_pen", PENABLE, 1'b1);
    chk1("w_acc_rspv", rsp_valid, 1'b0);
    step();
    chk1("w_rspv", rsp_valid, 1'b1);
    chk8("w_rdata", rsp_rdata, 8'h00);
    chk1("w_err", rsp_err, 1'b0);
    chk1("w_rsp_psel", PSEL, 1'b0);
    chk1("w_rsp_pen", PENABLE, 1'b0);
    step();
    chk1("w_done_rspv", rsp_valid, 1'b0);
    chk1("w_done_rdy", cmd_ready, 1'b1);
    chk8("w_hold_paddr", PADDR, 8'h04);

    // Read, 3 wait states, PERROR noise while not ready
    PREADY = 1'b0;
    PERROR = 1'b1;
    PRDATA = 8'h3C;
    issue(1'b0, 8'h10, 8'h99);
    step();
    cmd_valid = 1'b0;
    chk1("r_setup_pen", PENABLE, 1'b0);
    step();
    chk1("r_acc_pen", PENABLE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("r_wait_psel", PSEL, 1'b1);
      chk1("r_wait_pen", PENABLE, 1'b1);
      chk1("r_wait_pwrite", PWRITE, 1'b0);
      chk8("r_wait_paddr", PADDR, 8'h10);
      chk8("r_wait_pwdata", PWDATA, 8'h99);
      chk1("r_wait_rspv", rsp_valid, 1'b0);
    end
    PREADY = 1'b1;
    PERROR = 1'b0;
    step();
    chk1("r_rspv", rsp_valid, 1'b1);
    chk8("r_rdata", rsp_rdata, 8'h3C);
    chk1("r_err", rsp_err, 1'b0);
    step();
    chk1("r_done_rspv", rsp_valid, 1'b0);

    // Read with PERROR, then response back-pressure
    PERROR    = 1'b1;
    PRDATA    = 8'h77;
    rsp_ready = 1'b0;
    issue(1'b0, 8'h20, 8'h00);
    step();
    issue(1'b1, 8'h30, 8'h5A);
    step();
    step();
    chk1("e_rspv", rsp_valid, 1'b1);
    chk1("e_err", rsp_err, 1'b1);
    chk8("e_rdata", rsp_rdata, 8'h77);
    PERROR = 1'b0;
    PRDATA = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_rspv", rsp_valid, 1'b1);
      chk8("bp_rdata", rsp_rdata, 8'h77);
      chk1("bp_err", rsp_err, 1'b1);
      chk1("bp_rdy", cmd_ready, 1'b0);
      chk1("bp_psel", PSEL, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    chk1("bp_rel_rspv", rsp_valid, 1'b0);
    chk1("bp_rel_rdy", cmd_ready, 1'b1);
    chk1("bp_rel_psel", PSEL, 1'b0);
    step();
    cmd_valid = 1'b0;
    chk1("bp_new_psel", PSEL, 1'b1);
    chk8("bp_new_paddr", PADDR, 8'h30);
    chk1("bp_new_pwrite", PWRITE, 1'b1);
    step();
    step();
    chk1("bp_new_rspv", rsp_valid, 1'b1);
    chk1("bp_new_err", rsp_err, 1'b0);
    chk8("bp_new_rdata", rsp_rdata, 8'h00);
    step();

    // Reset during ACCESS
    PREADY = 1'b0;
    issue(1'b0, 8'h44, 8'h00);
    step();
    cmd_valid = 1'b0;
    step();
    chk1("ra_psel", PSEL, 1'b1);
    chk1("ra_pen", PENABLE, 1'b1);
    #2;
    PRESET = 1'b1;
    #1;
    chk1("ra_async_psel", PSEL, 1'b0);
    chk1("ra_async_pen", PENABLE, 1'b0);
    chk8("ra_async_paddr", PADDR, 8'h00);
    chk1("ra_async_rdy", cmd_ready, 1'b1);
    step();
    PRESET = 1'b0;
    PREADY = 1'b1;
    PRDATA = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("ra_no_rspv", rsp_valid, 1'b0);
      chk1("ra_no_psel", PSEL, 1'b0);
    end
    issue(1'b1, 8'h08, 8'hC3);
    step();
    cmd_valid = 1'b0;
    chk1("ra2_psel", PSEL, 1'b1);
    chk8("ra2_paddr", PADDR, 8'h08);
    chk8("ra2_pwdata", PWDATA, 8'hC3);
    step();
    chk1("ra2_pen", PENABLE, 1'b1);
    step();
    chk1("ra2_rspv", rsp_valid, 1'b1);
    chk8("ra2_rdata", rsp_rdata, 8'h00);
    chk1("ra2_err", rsp_err, 1'b0);
    step();

`ifdef UART_APB_MASTER_TIMEOUT_EN
    PREADY = 1'b0;
    issue(1'b0, 8'h50, 8'h00);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      chk1("to_wait_psel", PSEL, 1'b1);
    end
    step();
    chk1("to_psel", PSEL, 1'b0);
    chk1("to_pen", PENABLE, 1'b0);
    chk1("to_rspv", rsp_valid, 1'b1);
    chk1("to_err", rsp_err, 1'b1);
    chk8("to_rdata", rsp_rdata, 8'h00);
    PREADY = 1'b1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
